// File: rtl/wb_regfile_pkg.sv
// Shared sizing and reset constants for the writeback stage and register file.
package wb_regfile_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int NUM_REGS   = 16;

    localparam logic [DEF_WIDTH-1:0] REG_RST = '0;

endpackage

// File: rtl/wb_regfile_mux.sv
// Writeback value select: load data when the instruction was a load, ALU result otherwise.
module wb_mux #(
    parameter int WIDTH = 32
) (
    input  logic             i_sel_mem,
    input  logic [WIDTH-1:0] i_alu,
    input  logic [WIDTH-1:0] i_mem,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_sel_mem ? i_mem : i_alu;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage fused with the 16 x 32 architectural register file.
// Define WB_REGFILE_BYPASS_EN to let ID read a same-cycle write with zero latency.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_ENIn,
    input  logic              MEM_R_ENIn,
    input  logic [WIDTH-1:0]  ALUResIn,
    input  logic [WIDTH-1:0]  DataMemResIn,
    input  logic [ADDR_W-1:0] DestIn,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [WIDTH-1:0]  reg1,
    output logic [WIDTH-1:0]  reg2,
    output logic [WIDTH-1:0]  WB_Value,
    output logic [ADDR_W-1:0] WB_Dest,
    output logic              WB_EN,
    output logic [15:0]       wr_count
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [WIDTH-1:0] r_regs [N_REGS];
    logic [15:0]      r_wr_count;
    logic [WIDTH-1:0] w_value;
    logic             w_we;

    wb_mux #(.WIDTH(WIDTH)) u_wb_mux (
        .i_sel_mem (MEM_R_ENIn),
        .i_alu     (ALUResIn),
        .i_mem     (DataMemResIn),
        .o_value   (w_value)
    );

    assign w_we = WB_ENIn & ~freeze;

    // DestIn is only used as an index when the write is enabled, so an
    // unknown destination on an idle cycle cannot touch the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= WIDTH'(REG_RST);
            end
            r_wr_count <= '0;
        end else if (w_we) begin
            r_regs[DestIn] <= w_value;
            r_wr_count     <= r_wr_count + 16'd1;
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    assign reg1 = (w_we && (src1 == DestIn)) ? w_value : r_regs[src1];
    assign reg2 = (w_we && (src2 == DestIn)) ? w_value : r_regs[src2];
`else
    assign reg1 = r_regs[src1];
    assign reg2 = r_regs[src2];
`endif

    assign WB_Value = w_value;
    assign WB_Dest  = DestIn;
    assign WB_EN    = w_we;
    assign wr_count = r_wr_count;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the writeback stage fused with the architectural register file.
- Selects the writeback value: data-memory result for loads, ALU result otherwise.
- Commits that value into a 16 x 32 register file and serves the two ID-stage read ports.
- Sits between the MEM/WB register outputs and the ID stage, closing the pipeline loop.

Parameters:
- WIDTH, 32, data word width.
- ADDR_W, 4, register index width (2**ADDR_W registers).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets immediately, independent of clk).
- WB_ENIn  in  1  writeback enable from MEM/WB.
- MEM_R_ENIn  in  1  instruction was a load; selects memory data.
- ALUResIn  in  WIDTH  ALU result from MEM/WB.
- DataMemResIn  in  WIDTH  load data from MEM/WB.
- DestIn  in  ADDR_W  destination register index.
- freeze  in  1  global stall; when 1, no register write occurs.
- src1  in  ADDR_W  read port 1 index.
- src2  in  ADDR_W  read port 2 index.
- reg1  out  WIDTH  read port 1 data.
- reg2  out  WIDTH  read port 2 data.
- WB_Value  out  WIDTH  selected writeback value, for EXE forwarding.
- WB_Dest  out  ADDR_W  equals DestIn, for forwarding.
- WB_EN  out  1  effective write strobe, i.e. WB_ENIn & ~freeze, for forwarding.
- wr_count  out  16  committed-write counter.

Behaviour:
- Value select (combinational): WB_Value = MEM_R_ENIn ? DataMemResIn : ALUResIn.
- Write commit: on posedge clk, if rst==1 and WB_ENIn==1 and freeze==0, then regs[DestIn] <= WB_Value. Written data is visible in the array from the next cycle.
- Reads (combinational):
  - reg1 = regs[src1], reg2 = regs[src2].
  - Bypass rules are given under Optional Feature.
- Two read ports may address the same register; both return identical data.
- No write-port conflict is possible: there is a single write port.
- wr_count:
  - Increments by 1 on every committed write.
  - Wraps from 16'hFFFF to 0.
  - Holds when freeze==1 or WB_ENIn==0.
- Reset:
  - rst==0 asynchronously clears all 16 registers and wr_count to 0.
  - reg1 and reg2 therefore read 0 during reset.
  - WB_Value, WB_Dest and WB_EN follow their inputs and are not stored.
- Reset mid-write: reset wins; the array is all zeros after reset deasserts. A write is captured only on the first posedge with rst==1.
- Register 15 is an ordinary storage location; no special casing.
- MEM_R_ENIn with WB_ENIn==0: no write occurs. WB_Value still reflects DataMemResIn.
- X on DestIn while WB_ENIn==0 must not corrupt any register.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: write-through bypass.
  - If WB_EN==1 and src1==DestIn, reg1 = WB_Value; same rule for src2/reg2.
  - A same-cycle write is seen by ID with 0 extra latency.
- Undefined: reg1/reg2 read the array only. The new value appears one cycle after commit; the hazard unit must cover that cycle.

Decomposition:
- Shared package holds:
  - WIDTH and ADDR_W defaults.
  - NUM_REGS = 16.
  - Reset value constant REG_RST = 0.
- One natural sub-module, wb_mux: the 2:1 writeback value select.
- Register array and counter stay in the top module.

Test Plan:
- Reset, async: drive rst=0 mid-cycle after loading R3=32'h1234 -> reg1 (src1=3) reads 0 immediately, before the next clk edge; wr_count=0.
- ALU writeback: WB_ENIn=1, MEM_R_ENIn=0, ALUResIn=32'hA5A5_0001, DestIn=5 -> after 1 posedge, src1=5 gives reg1=32'hA5A5_0001; wr_count=1.
- Load writeback: MEM_R_ENIn=1, DataMemResIn=32'hDEAD_BEEF, ALUResIn=32'h0, DestIn=15 -> WB_Value=32'hDEAD_BEEF; after posedge, R15=32'hDEAD_BEEF.
- Freeze: freeze=1, WB_ENIn=1, DestIn=2, ALUResIn=7 -> R2 unchanged (0); WB_EN=0; wr_count unchanged.
- Bypass, same cycle: write DestIn=4, ALUResIn=32'h55 with src1=src2=4 ->
  - Macro defined: reg1=reg2=32'h55 in the same cycle.
  - Macro undefined: old value in that cycle, 32'h55 the next cycle.
- Counter wrap: preload 65535 committed writes, then one more -> wr_count=0.
